// File: rtl/alu_decode_stage.sv
// alu_decode_stage: single-entry ID/EX register that decodes an RV32I word
// into the ALU operation code, operand selects, immediate and control bits.
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_ctrl,
  output logic        src1_pc,
  output logic        src2_imm,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal,
  output logic [31:0] pc_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f3_add_or_sr;

  logic [3:0]  alu_ctrl_next;
  logic        src1_pc_next;
  logic        src2_imm_next;
  logic [31:0] imm_next;
  logic        reg_write_next;
  logic        mem_read_next;
  logic        mem_write_next;
  logic        illegal_next;

  logic        out_valid_reg;
  logic        load_en;

  assign opcode       = inst_i[6:0];
  assign f3           = inst_i[14:12];
  assign f7           = inst_i[31:25];
  assign f3_add_or_sr = (f3 == 3'b000) || (f3 == 3'b101);

  assign in_ready  = !out_valid_reg || out_ready;
  assign load_en   = in_valid && in_ready && !flush;
  assign out_valid = out_valid_reg;

  // Decode the incoming word; any illegal encoding forces every control to zero.
  always_comb begin
    alu_ctrl_next  = 4'b0000;
    src1_pc_next   = 1'b0;
    src2_imm_next  = 1'b0;
    imm_next       = 32'd0;
    reg_write_next = 1'b0;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    illegal_next   = 1'b0;
    case (opcode)
      OP_R: begin
        if ((f7 == 7'b0000000) || ((f7 == 7'b0100000) && f3_add_or_sr)) begin
          alu_ctrl_next  = {inst_i[30] & f3_add_or_sr, f3};
          reg_write_next = 1'b1;
        end else begin
          illegal_next = 1'b1;
        end
      end
      OP_I: begin
        // Only shifts constrain the upper bits; bit 30 selects SRA for f3=101 only.
        if (((f3 == 3'b001) && (f7 != 7'b0000000)) ||
            ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000))) begin
          illegal_next = 1'b1;
        end else begin
          alu_ctrl_next  = {(f3 == 3'b101) & inst_i[30], f3};
          src2_imm_next  = 1'b1;
          imm_next       = {{20{inst_i[31]}}, inst_i[31:20]};
          reg_write_next = 1'b1;
        end
      end
      OP_LUI: begin
        alu_ctrl_next  = 4'b1001;
        src2_imm_next  = 1'b1;
        imm_next       = {inst_i[31:12], 12'd0};
        reg_write_next = 1'b1;
      end
      OP_AUIPC: begin
        src1_pc_next   = 1'b1;
        src2_imm_next  = 1'b1;
        imm_next       = {inst_i[31:12], 12'd0};
        reg_write_next = 1'b1;
      end
      OP_LOAD: begin
        src2_imm_next  = 1'b1;
        imm_next       = {{20{inst_i[31]}}, inst_i[31:20]};
        mem_read_next  = 1'b1;
        reg_write_next = 1'b1;
      end
      OP_STORE: begin
        src2_imm_next  = 1'b1;
        imm_next       = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        mem_write_next = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase
  end

  // Pipeline register: reset beats flush, flush beats load, consume empties the slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      alu_ctrl      <= 4'b0000;
      src1_pc       <= 1'b0;
      src2_imm      <= 1'b0;
      imm           <= 32'd0;
      rs1           <= 5'd0;
      rs2           <= 5'd0;
      rd            <= 5'd0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      illegal       <= 1'b0;
      pc_o          <= 32'd0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (load_en) begin
      out_valid_reg <= 1'b1;
      alu_ctrl      <= alu_ctrl_next;
      src1_pc       <= src1_pc_next;
      src2_imm      <= src2_imm_next;
      imm           <= imm_next;
      rs1           <= inst_i[19:15];
      rs2           <= inst_i[24:20];
      rd            <= inst_i[11:7];
      reg_write     <= reg_write_next;
      mem_read      <= mem_read_next;
      mem_write     <= mem_write_next;
      illegal       <= illegal_next;
      pc_o          <= pc_i;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage with hand-computed expectations.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst_i, pc_i, imm, pc_o;
  logic [3:0]  alu_ctrl;
  logic        src1_pc, src2_imm, reg_write, mem_read, mem_write, illegal;
  logic [4:0]  rs1, rs2, rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst_i), .pc_i(pc_i), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl), .src1_pc(src1_pc),
    .src2_imm(src2_imm), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .illegal(illegal), .pc_o(pc_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    inst_i   = inst;
    pc_i     = pc;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    inst_i = 32'd0; pc_i = 32'd0;
    tick(); tick();
    check_val("rst out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    check_val("rst imm", imm, 32'd0);
    check_val("rst in_ready", {31'd0, in_ready}, 32'd1);

    // add x3,x1,x2
    rst_n = 1'b1; out_ready = 1'b1;
    drive(32'h002081B3, 32'h100);
    tick();
    check_val("add out_valid", {31'd0, out_valid}, 32'd1);
    check_val("add alu_ctrl", {28'd0, alu_ctrl}, 32'h0);
    check_val("add rs1/rs2/rd", {17'd0, rs1, rs2, rd}, {17'd0, 5'd1, 5'd2, 5'd3});
    check_val("add reg_write", {31'd0, reg_write}, 32'd1);
    check_val("add src2_imm", {31'd0, src2_imm}, 32'd0);
    check_val("add pc_o", pc_o, 32'h100);

    // sub then srai back to back
    drive(32'h402081B3, 32'h104);
    tick();
    check_val("sub alu_ctrl", {28'd0, alu_ctrl}, 32'h8);
    drive(32'h40335293, 32'h108);
    tick();
    check_val("srai out_valid", {31'd0, out_valid}, 32'd1);
    check_val("srai alu_ctrl", {28'd0, alu_ctrl}, 32'hD);
    check_val("srai imm", imm, 32'h00000403);
    check_val("srai rs1/rd", {22'd0, rs1, rd}, {22'd0, 5'd6, 5'd5});

    // lui x7,0x12345
    drive(32'h123453B7, 32'h10C);
    tick();
    check_val("lui alu_ctrl", {28'd0, alu_ctrl}, 32'h9);
    check_val("lui imm", imm, 32'h12345000);
    check_val("lui src2_imm", {31'd0, src2_imm}, 32'd1);
    check_val("lui rd", {27'd0, rd}, 32'd7);

    // backpressure: addi x1,x0,5 pending while consumer stalls
    out_ready = 1'b0;
    drive(32'h00500093, 32'h110);
    #1;
    check_val("stall in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("stall out_valid", {31'd0, out_valid}, 32'd1);
      check_val("stall alu_ctrl", {28'd0, alu_ctrl}, 32'h9);
      check_val("stall imm", imm, 32'h12345000);
      check_val("stall pc_o", pc_o, 32'h10C);
      check_val("stall in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check_val("addi alu_ctrl", {28'd0, alu_ctrl}, 32'h0);
    check_val("addi imm", imm, 32'd5);
    check_val("addi rd", {27'd0, rd}, 32'd1);
    check_val("addi pc_o", pc_o, 32'h110);

    // flush alone while holding
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check_val("hold out_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    tick();
    check_val("flush out_valid", {31'd0, out_valid}, 32'd0);
    // flush with a transfer-in attempt
    drive(32'h402081B3, 32'h114);
    check_val("flush in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_val("flush+in out_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check_val("dropped out_valid", {31'd0, out_valid}, 32'd0);
    check_val("dropped pc_o", pc_o, 32'h110);

    // illegal encodings
    out_ready = 1'b1;
    drive(32'h0000007F, 32'h118);
    tick();
    check_val("badop out_valid", {31'd0, out_valid}, 32'd1);
    check_val("badop illegal", {31'd0, illegal}, 32'd1);
    check_val("badop reg_write", {31'd0, reg_write}, 32'd0);
    check_val("badop alu_ctrl", {28'd0, alu_ctrl}, 32'h0);
    drive(32'h80208033, 32'h11C);
    tick();
    check_val("badf7 illegal", {31'd0, illegal}, 32'd1);
    check_val("badf7 reg_write", {31'd0, reg_write}, 32'd0);
    check_val("badf7 alu_ctrl", {28'd0, alu_ctrl}, 32'h0);
    drive(32'h40109093, 32'h120);
    tick();
    check_val("badslli illegal", {31'd0, illegal}, 32'd1);
    check_val("badslli src2_imm", {31'd0, src2_imm}, 32'd0);

    // sw x2,8(x1)
    drive(32'h0020A423, 32'h124);
    tick();
    check_val("sw illegal", {31'd0, illegal}, 32'd0);
    check_val("sw mem_write", {31'd0, mem_write}, 32'd1);
    check_val("sw reg_write", {31'd0, reg_write}, 32'd0);
    check_val("sw imm", imm, 32'd8);
    // lw x4,-4(x1)
    drive(32'hFFC0A203, 32'h128);
    tick();
    check_val("lw mem_read", {31'd0, mem_read}, 32'd1);
    check_val("lw reg_write", {31'd0, reg_write}, 32'd1);
    check_val("lw imm", imm, 32'hFFFFFFFC);
    check_val("lw mem_write", {31'd0, mem_write}, 32'd0);
    // auipc x8,1
    drive(32'h00001417, 32'h12C);
    tick();
    check_val("auipc src1_pc", {31'd0, src1_pc}, 32'd1);
    check_val("auipc alu_ctrl", {28'd0, alu_ctrl}, 32'h0);
    check_val("auipc imm", imm, 32'h00001000);

    // reset mid-stall drops the held entry
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    check_val("mrst out_valid", {31'd0, out_valid}, 32'd0);
    check_val("mrst alu_ctrl", {28'd0, alu_ctrl}, 32'h0);
    check_val("mrst imm", imm, 32'd0);
    check_val("mrst pc_o", pc_o, 32'd0);
    check_val("mrst rd", {27'd0, rd}, 32'd0);
    check_val("mrst ctrls", {26'd0, src1_pc, src2_imm, reg_write, mem_read, mem_write, illegal}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered ID/EX decode stage that turns a fetched RV32I instruction word into the 4-bit ALU operation code and operand selects the execute-stage ALU consumes. It sits between the fetch/register-file read and the ALU. It is a single-entry pipeline register with valid/ready handshakes on both sides, plus stall and flush hooks. The opcode-to-alu_ctrl mapping here is the authoritative encoder for the ALU's operation encoding.

## Interface
- No parameters; data width is fixed at 32.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  inst_i and pc_i are valid.
- in_ready  output  1  stage can accept; combinational, equal to !out_valid || out_ready.
- inst_i  input  32  instruction word.
- pc_i  input  32  instruction address.
- flush  input  1  kill the held entry and any incoming instruction this cycle.
- out_valid  output  1  decoded entry held.
- out_ready  input  1  execute stage consumes the entry.
- alu_ctrl  output  4  operation code: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, LUI(pass src2) 1001.
- src1_pc  output  1  ALU src1 is pc_o rather than rs1 data.
- src2_imm  output  1  ALU src2 is imm rather than rs2 data.
- imm  output  32  sign-extended or U-format immediate.
- rs1, rs2, rd  output  5 each  register indices taken directly from inst bits [19:15], [24:20], [11:7].
- reg_write, mem_read, mem_write  output  1 each  writeback and memory controls.
- illegal  output  1  unsupported or malformed encoding.
- pc_o  output  32  registered pc_i.

## Operation
- Transfer in: in_valid && in_ready && !flush. Transfer out: out_valid && out_ready.
- R-type (opcode 0110011): alu_ctrl = {inst[30] & (f3==000 | f3==101), f3}; src2_imm=0; reg_write=1.
  - funct7 must be 0000000, or 0100000 with f3 000/101; otherwise illegal.
- I-ALU (0010011): src2_imm=1; imm = sext(inst[31:20]); reg_write=1.
  - alu_ctrl = {f3==101 & inst[30], f3}. ADDI never yields SUB.
  - Shifts (f3 001/101) require inst[31:25] = 0000000, or 0100000 for f3 101 only; otherwise illegal.
- LUI (0110111): alu_ctrl 1001, src2_imm=1, imm = {inst[31:12], 12'b0}, reg_write=1.
- AUIPC (0010111): ADD, src1_pc=1, src2_imm=1, U-immediate, reg_write=1.
- Load (0000011): ADD, I-immediate, mem_read=1, reg_write=1.
- Store (0100011): ADD, S-immediate {sext(inst[31:25]), inst[11:7]}, mem_write=1, reg_write=0.
- Any other opcode: illegal=1, alu_ctrl 0000, all selects and controls 0.
- An illegal entry still flows through the handshake; the execute stage decides trap handling.
- Every output other than in_ready is registered and changes only when an entry is loaded, or on reset or flush.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N is presented at out_valid from edge N onward until consumed.
- Throughput: 1 per cycle. A simultaneous consume and accept in the same cycle overwrites the entry with no bubble.
- Backpressure: while out_valid && !out_ready, the entry is held stable and in_ready=0.
- Flush: at the next edge out_valid=0 regardless of out_ready, in_valid or a concurrent handshake. Flush has priority over load.
- Reset (rst_n low at an edge): out_valid=0, alu_ctrl=0000, imm=0, pc_o=0, rs1/rs2/rd=0, all 1-bit controls 0. Reset has priority over flush and load.
- Reset asserted mid-stall drops the held entry.

## Test plan
- Reset, then inst 0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, alu_ctrl=0000, rs1=1, rs2=2, rd=3, reg_write=1, src2_imm=0.
- inst 0x402081B3 (sub) then 0x40335293 (srai x5,x6,3), back-to-back with out_ready=1 -> alu_ctrl 1000 then 1101, imm=0x00000403, no bubble.
- inst 0x123453B7 (lui x7,0x12345) -> alu_ctrl=1001, imm=0x12345000, src2_imm=1, rd=7.
- Hold out_ready=0 for 3 cycles with a new in_valid pending -> in_ready=0, outputs unchanged; the pending instruction loads the cycle after out_ready=1.
- Assert flush alone while holding an entry -> out_valid=0 next cycle. Assert flush together with in_valid=1 and in_ready=1 -> out_valid stays 0 and the incoming instruction is dropped.
- inst 0x0000007F (bad opcode) and 0x80208033 (bad funct7) -> illegal=1, reg_write=0, alu_ctrl=0000; rst_n=0 for one edge then -> all outputs at their reset values.
